// File: rtl/uart_dump_ctrl.sv
// Streams num_bytes DRAM bytes starting at base_addr to the UART transmitter, one frame per byte.
// Define UART_DUMP_CHECKSUM_EN to append a modulo-256 checksum frame to every dump.
module uart_dump_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1,
  parameter int BYTE_GAP    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_bytes,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);
  localparam int CMAX = (MEM_LATENCY > BYTE_GAP) ? MEM_LATENCY : BYTE_GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] LAT_LAST = CW'(MEM_LATENCY - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, TX_REQ, TX_WAIT, GAP, FINISH} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [CW-1:0]         cnt;
  logic                  tx_done_q, abort_flag, busy_q, aborted_q;
  logic                  tx_edge, abort_any, last_byte;
`ifdef UART_DUMP_CHECKSUM_EN
  logic [7:0]            csum;
  logic                  csum_phase;
`endif

  // tx_done idles high, so only a fresh rise marks the end of our own frame
  assign tx_edge   = tx_done & ~tx_done_q;
  assign abort_any = abort_flag | abort;
  assign last_byte = (remaining == REM_ONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) begin
`ifdef UART_DUMP_CHECKSUM_EN
        state_nxt = (num_bytes == '0) ? TX_REQ : RD_REQ;
`else
        state_nxt = (num_bytes == '0) ? FINISH : RD_REQ;
`endif
      end
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: if (cnt == LAT_LAST) state_nxt = TX_REQ;
      TX_REQ:  state_nxt = TX_WAIT;
      TX_WAIT: if (tx_edge) begin
`ifdef UART_DUMP_CHECKSUM_EN
        if (csum_phase)                  state_nxt = FINISH;
        else if (abort_any || last_byte) state_nxt = TX_REQ;
`else
        if (abort_any || last_byte)      state_nxt = FINISH;
`endif
        else if (BYTE_GAP > 0)           state_nxt = GAP;
        else                             state_nxt = RD_REQ;
      end
      GAP:     if (cnt == GAP_LAST) state_nxt = RD_REQ;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      cnt        <= '0;
      tx_data    <= '0;
      tx_done_q  <= 1'b0;
      abort_flag <= 1'b0;
      busy_q     <= 1'b0;
      aborted_q  <= 1'b0;
`ifdef UART_DUMP_CHECKSUM_EN
      csum       <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      tx_done_q <= tx_done;
      cnt       <= (state_nxt != state) ? '0 : cnt + CW'(1);
      if (state != IDLE && abort) abort_flag <= 1'b1;
      case (state)
        IDLE: if (start) begin
          addr       <= base_addr;
          remaining  <= num_bytes;
          abort_flag <= 1'b0;
          aborted_q  <= 1'b0;
          busy_q     <= 1'b1;
`ifdef UART_DUMP_CHECKSUM_EN
          csum       <= '0;
          csum_phase <= (num_bytes == '0);
          if (num_bytes == '0) tx_data <= '0;
`endif
        end
        RD_WAIT: if (cnt == LAT_LAST) tx_data <= mem_rdata;
`ifdef UART_DUMP_CHECKSUM_EN
        TX_REQ: if (!csum_phase) csum <= csum + tx_data;
`endif
        TX_WAIT: if (tx_edge) begin
`ifdef UART_DUMP_CHECKSUM_EN
          if (!csum_phase) begin
            remaining <= remaining - REM_ONE;
            addr      <= addr + ADDR_ONE;
            // last data frame done: reuse TX_REQ/TX_WAIT for the checksum byte
            if (abort_any || last_byte) begin
              csum_phase <= 1'b1;
              tx_data    <= csum;
            end
          end
`else
          remaining <= remaining - REM_ONE;
          addr      <= addr + ADDR_ONE;
`endif
          if (state_nxt == FINISH) aborted_q <= abort_any;
        end
        FINISH:  busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_rd_en = (state == RD_REQ);
  assign mem_addr  = addr;
  assign tx_start  = (state == TX_REQ);
  assign busy      = busy_q;
  assign done      = (state == FINISH);
  assign aborted   = aborted_q;
endmodule

// File: tb/tb_uart_dump_ctrl.sv
// Directed bench for uart_dump_ctrl: DRAM and UART transmitter models, one task per scenario.
module tb_uart_dump_ctrl;
  localparam int FRAME = 6;
`ifdef UART_DUMP_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] base_addr = '0;
  logic [16:0] num_bytes = '0;
  logic        mem_rd_en, tx_start, busy, done, aborted;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = '0, tx_data;
  logic        tx_done;
  logic [7:0]  mem [0:65535];
  int          ucnt;
  int          checks = 0, failures = 0, cyc = 0;
  logic        tdp = 1'b1;
  logic [15:0] rd_q[$];
  logic [7:0]  tx_q[$];
  int          txc_q[$], rise_q[$];

  uart_dump_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .num_bytes(num_bytes),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DRAM with one cycle read latency
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // UART: tx_done stays high the cycle after accept, low for the frame, then rises
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done <= 1'b1;
      ucnt    <= 0;
    end else if (tx_start) begin
      ucnt <= FRAME;
    end else if (ucnt != 0) begin
      ucnt    <= ucnt - 1;
      tx_done <= (ucnt == 1);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en) rd_q.push_back(mem_addr);
      if (tx_start) begin tx_q.push_back(tx_data); txc_q.push_back(cyc); end
      if (tx_done && !tdp) rise_q.push_back(cyc);
    end
    tdp = tx_done;
  end

  function automatic logic [7:0] txb(input int i);
    return (i >= 0 && i < tx_q.size()) ? tx_q[i] : 8'hxx;
  endfunction
  function automatic logic [15:0] rda(input int i);
    return (i >= 0 && i < rd_q.size()) ? rd_q[i] : 16'hxxxx;
  endfunction
  function automatic int txc_at(input int i);
    return (i >= 0 && i < txc_q.size()) ? txc_q[i] : -999;
  endfunction
  function automatic int rise_at(input int i);
    return (i >= 0 && i < rise_q.size()) ? rise_q[i] : -999;
  endfunction

  task automatic do_start(input logic [15:0] b, input logic [16:0] n, output int s);
    @(negedge clk);
    rd_q.delete(); tx_q.delete(); txc_q.delete(); rise_q.delete();
    base_addr = b; num_bytes = n; start = 1'b1; s = cyc;
  endtask

  task automatic wait_done(input int budget, input bit keep, output int at, output logic ab, output bit ok);
    ok = 1'b0; at = -1; ab = 1'bx;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!keep) start = 1'b0;
      if (done) begin ok = 1'b1; at = cyc; ab = aborted; start = 1'b0; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int s;
    repeat (2) @(negedge clk);
    checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en got=%b exp=0", mem_rd_en); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
    checks++; if ({busy, done, aborted} !== 3'b000) begin failures++; $display("FAIL rst_status got=%b exp=000", {busy, done, aborted}); end
    checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0000", mem_addr); end
    checks++; if (tx_data !== 8'h0) begin failures++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    rst_n = 1'b1;
    // reset asserted while the controller waits on DRAM data
    mem[16'h0010] = 8'h41;
    do_start(16'h0010, 17'd4, s);
    @(negedge clk); start = 1'b0;
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0010) begin failures++; $display("FAIL mid_rd_req got=%b/%h exp=1/0010", mem_rd_en, mem_addr); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mem_rd_en, tx_start, busy, done} !== 4'b0000) begin failures++; $display("FAIL mid_reset_outs got=%b exp=0000", {mem_rd_en, tx_start, busy, done}); end
    checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL mid_reset_addr got=%h exp=0000", mem_addr); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int s, at; logic ab; bit ok;
    logic [7:0] exp [4];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43; exp[3] = 8'h44;
    for (int i = 0; i < 4; i++) mem[16'h0010 + i] = exp[i];
    do_start(16'h0010, 17'd4, s);
    wait_done(400, 1'b0, at, ab, ok);
    @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout done not seen within 400 cycles"); end
    checks++; if (tx_q.size() != 4 + EXTRA) begin failures++; $display("FAIL basic_frames got=%0d exp=%0d", tx_q.size(), 4 + EXTRA); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (txb(i) !== exp[i]) begin failures++; $display("FAIL basic_byte%0d got=%h exp=%h", i, txb(i), exp[i]); end
    end
`ifdef UART_DUMP_CHECKSUM_EN
    checks++; if (txb(4) !== 8'h0A) begin failures++; $display("FAIL basic_csum got=%h exp=0a", txb(4)); end
`endif
    checks++; if (rd_q.size() != 4 || rda(3) !== 16'h0013) begin failures++; $display("FAIL basic_reads got=%0d/%h exp=4/0013", rd_q.size(), rda(3)); end
    checks++; if (txc_at(0) != s + 3) begin failures++; $display("FAIL basic_first_latency got=%0d exp=%0d", txc_at(0), s + 3); end
    checks++; if (txc_at(1) != rise_at(0) + 3) begin failures++; $display("FAIL basic_gap got=%0d exp=%0d", txc_at(1), rise_at(0) + 3); end
    checks++; if (at != rise_at(3 + EXTRA) + 1) begin failures++; $display("FAIL basic_done_time got=%0d exp=%0d", at, rise_at(3 + EXTRA) + 1); end
    checks++; if (ab !== 1'b0) begin failures++; $display("FAIL basic_aborted got=%b exp=0", ab); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_zero();
    int s, at; logic ab; bit ok;
    do_start(16'h0123, 17'd0, s);
    wait_done(100, 1'b0, at, ab, ok);
    @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL zero_timeout done not seen within 100 cycles"); end
    checks++; if (rd_q.size() != 0) begin failures++; $display("FAIL zero_reads got=%0d exp=0", rd_q.size()); end
    checks++; if (tx_q.size() != EXTRA) begin failures++; $display("FAIL zero_frames got=%0d exp=%0d", tx_q.size(), EXTRA); end
`ifdef UART_DUMP_CHECKSUM_EN
    checks++; if (txb(0) !== 8'h00) begin failures++; $display("FAIL zero_csum got=%h exp=00", txb(0)); end
    checks++; if (at != rise_at(0) + 1) begin failures++; $display("FAIL zero_done_time got=%0d exp=%0d", at, rise_at(0) + 1); end
`else
    checks++; if (at != s + 1) begin failures++; $display("FAIL zero_done_time got=%0d exp=%0d", at, s + 1); end
`endif
  endtask

  task automatic test_wrap();
    int s, at; logic ab; bit ok;
    mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hA5;
    do_start(16'hFFFF, 17'd2, s);
    wait_done(300, 1'b0, at, ab, ok);
    @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout done not seen within 300 cycles"); end
    checks++; if (rd_q.size() != 2) begin failures++; $display("FAIL wrap_reads got=%0d exp=2", rd_q.size()); end
    checks++; if (rda(0) !== 16'hFFFF || rda(1) !== 16'h0000) begin failures++; $display("FAIL wrap_addrs got=%h,%h exp=ffff,0000", rda(0), rda(1)); end
    checks++; if (txb(0) !== 8'h5A || txb(1) !== 8'hA5) begin failures++; $display("FAIL wrap_data got=%h,%h exp=5a,a5", txb(0), txb(1)); end
  endtask

  task automatic test_abort();
    int s, at, n, k; logic ab; bit ok;
    for (int i = 0; i < 5; i++) mem[16'h0020 + i] = 8'h60 + 8'(i);
    do_start(16'h0020, 17'd5, s);
    @(negedge clk); base_addr = 16'h0099; num_bytes = 17'd1;
    n = 0; k = 0;
    while (n < 2 && k < 200) begin @(negedge clk); if (tx_start) n++; k++; end
    checks++; if (n != 2) begin failures++; $display("FAIL abort_second_frame got=%0d exp=2", n); end
    repeat (3) @(negedge clk); abort = 1'b1;
    repeat (2) @(negedge clk); abort = 1'b0;
    wait_done(300, 1'b1, at, ab, ok);
    @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL abort_timeout done not seen within 300 cycles"); end
    checks++; if (rd_q.size() != 2 || rda(1) !== 16'h0021) begin failures++; $display("FAIL abort_reads got=%0d/%h exp=2/0021", rd_q.size(), rda(1)); end
    checks++; if (tx_q.size() != 2 + EXTRA || txb(1) !== 8'h61) begin failures++; $display("FAIL abort_frames got=%0d/%h exp=%0d/61", tx_q.size(), txb(1), 2 + EXTRA); end
`ifdef UART_DUMP_CHECKSUM_EN
    checks++; if (txb(2) !== 8'hC1) begin failures++; $display("FAIL abort_csum got=%h exp=c1", txb(2)); end
`endif
    checks++; if (at != rise_at(1 + EXTRA) + 1) begin failures++; $display("FAIL abort_done_time got=%0d exp=%0d", at, rise_at(1 + EXTRA) + 1); end
    checks++; if (ab !== 1'b1) begin failures++; $display("FAIL abort_flag got=%b exp=1", ab); end
    repeat (3) @(negedge clk);
    checks++; if (aborted !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_hold got=%b/%b exp=1/0", aborted, busy); end
  endtask

  task automatic test_sum();
    int s, at; logic ab; bit ok;
    mem[16'h0040] = 8'hFF; mem[16'h0041] = 8'h02;
    do_start(16'h0040, 17'd2, s);
    @(negedge clk); start = 1'b0;
    checks++; if (aborted !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL sum_start_state got=%b/%b exp=0/1", aborted, busy); end
    wait_done(300, 1'b0, at, ab, ok);
    @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL sum_timeout done not seen within 300 cycles"); end
    checks++; if (tx_q.size() != 2 + EXTRA || txb(0) !== 8'hFF || txb(1) !== 8'h02) begin failures++; $display("FAIL sum_frames got=%0d %h %h exp=%0d ff 02", tx_q.size(), txb(0), txb(1), 2 + EXTRA); end
`ifdef UART_DUMP_CHECKSUM_EN
    checks++; if (txb(2) !== 8'h01) begin failures++; $display("FAIL sum_csum got=%h exp=01", txb(2)); end
`endif
    checks++; if (at != rise_at(1 + EXTRA) + 1) begin failures++; $display("FAIL sum_done_time got=%0d exp=%0d", at, rise_at(1 + EXTRA) + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_wrap();
    test_abort();
    test_sum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
